// File: rtl/hc_adder_pkg.sv
// Shared definitions for the Han-Carlson adder post-processing stage.
package hc_adder_pkg;

    // Default operand width of the adder datapath.
    localparam int DEFAULT_WIDTH = 16;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Status flags carried with every sum.
    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } hc_flags_t;

    // Builds the flag record from the prefix-tree carries and the finished sum.
    function automatic hc_flags_t make_flags(input logic carry_msb_out,
                                             input logic carry_msb_in,
                                             input logic sum_is_zero);
        hc_flags_t f;
        f.cout = carry_msb_out;
        f.ovf  = carry_msb_out ^ carry_msb_in;
        f.zero = sum_is_zero;
        return f;
    endfunction

endpackage

// File: rtl/hc_skid_buffer.sv
// Generic two-entry valid/ready skid register with a registered in_ready.
module hc_skid_buffer
    import hc_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state;
    skid_state_t  next_state;
    logic [W-1:0] m_data;
    logic [W-1:0] s_data;
    logic         ready_q;
    logic         acc;
    logic         pop;
    logic         load_m;
    logic         load_s;
    logic         move_s;

    // State register; ready_q mirrors "next state is not FULL" so in_ready is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != FULL);
        end
    end

    // Main and skid data registers; a record always moves as one word.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data <= '0;
            s_data <= '0;
        end else begin
            if (load_m) begin
                m_data <= in_data;
            end else if (move_s) begin
                m_data <= s_data;
            end
            if (load_s) begin
                s_data <= in_data;
            end
        end
    end

    // Next-state and register-load decisions from the two handshakes.
    always_comb begin
        next_state = state;
        load_m     = 1'b0;
        load_s     = 1'b0;
        move_s     = 1'b0;
        acc        = in_valid & in_ready;
        pop        = out_valid & out_ready;
        case (state)
            EMPTY: begin
                if (acc) begin
                    load_m     = 1'b1;
                    next_state = ONE;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    load_m = 1'b1;
                end else if (acc) begin
                    load_s     = 1'b1;
                    next_state = FULL;
                end else if (pop) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    move_s     = 1'b1;
                    next_state = ONE;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

    // Outputs: ready is held low during reset, M always drives the data.
    always_comb begin
        in_ready  = ready_q & ~rst;
        out_valid = (state != EMPTY);
        out_data  = m_data;
    end

endmodule

// File: rtl/hc_sum_stage.sv
// Sum and flag generation after the Han-Carlson prefix tree, registered
// behind a skid buffer so the stage keeps full throughput.
module hc_sum_stage
    import hc_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_p,
    input  logic [WIDTH-1:0] in_gc,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        hc_flags_t        flags;
    } result_t;

    result_t in_rec;
    result_t out_rec;

    // Carry into bit i is the group generate of bit i-1, cin for bit 0.
    always_comb begin
        in_rec.sum   = in_p ^ {in_gc[WIDTH-2:0], in_cin};
        in_rec.flags = make_flags(in_gc[WIDTH-1], in_gc[WIDTH-2], ~|in_rec.sum);
    end

    hc_skid_buffer #(
        .W($bits(result_t))
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_rec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_rec)
    );

    // Unpack the registered record onto the output fields.
    always_comb begin
        out_sum  = out_rec.sum;
        out_cout = out_rec.flags.cout;
        out_ovf  = out_rec.flags.ovf;
        out_zero = out_rec.flags.zero;
    end

endmodule

// File: tb/tb_hc_sum_stage.sv
// Self-checking bench for hc_sum_stage at WIDTH=8 with a scoreboard queue.
module tb_hc_sum_stage;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } rec_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_p;
    logic [W-1:0] in_gc;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int   checks;
    int   errors;
    rec_t sb[$];
    rec_t cur_exp;
    rec_t exp_rec;
    rec_t got_rec;

    hc_sum_stage #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_p     (in_p),
        .in_gc    (in_gc),
        .in_cin   (in_cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_zero (out_zero)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: a plain integer add of the original operands.
    function automatic rec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        rec_t r;
        logic [W:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    // Builds propagate and ripple group-generate vectors as the prefix tree would.
    task automatic set_in(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic carry;
        carry = c;
        for (int i = 0; i < W; i++) begin
            carry    = (a[i] & b[i]) | ((a[i] ^ b[i]) & carry);
            in_gc[i] = carry;
        end
        in_p     = a ^ b;
        in_cin   = c;
        in_valid = v;
        cur_exp  = model(a, b, c);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_p      = '0;
        in_gc     = '0;
        in_cin    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b sum=%h flags=%b%b%b, need all 0",
                     out_valid, out_sum, out_cout, out_ovf, out_zero);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b, need 0", in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_in_ready: got %b, need 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{8'h7F, 8'hFF, 8'h00, 8'h80, 8'h55};
        logic [W-1:0] vb [5] = '{8'h01, 8'h01, 8'h00, 8'h80, 8'hAA};
        logic         vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) set_in(1'b1, va[i], vb[i], vc[i]);
            else       in_valid = 1'b0;
            @(negedge clk);
            if (i >= 1 && i <= 5) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL directed_latency[%0d]: out_valid=%b, need 1", i, out_valid);
                end
            end
            if (i >= 6) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL idle_ready_no_effect[%0d]: out_valid=%b, need 0", i, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                got_rec = {out_sum, out_cout, out_ovf, out_zero};
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL directed_spurious: got %h with empty scoreboard", got_rec);
                end else begin
                    exp_rec = sb.pop_front();
                    if (got_rec !== exp_rec) begin
                        errors++;
                        $display("[TB] FAIL directed_result: got sum=%h c/o/z=%b%b%b, need sum=%h c/o/z=%b%b%b",
                                 got_rec.sum, got_rec.cout, got_rec.ovf, got_rec.zero,
                                 exp_rec.sum, exp_rec.cout, exp_rec.ovf, exp_rec.zero);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ba [4] = '{8'h10, 8'h22, 8'h3C, 8'hF0};
        logic [W-1:0] bb [4] = '{8'h01, 8'h0E, 8'h44, 8'h10};
        int idx  = 0;
        int pops = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1, ba[idx], bb[idx], 1'b0);
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL full_in_ready[%0d]: got %b, need 0", c, in_ready);
                end
            end
            if (c == 3) begin
                checks++;
                got_rec = {out_sum, out_cout, out_ovf, out_zero};
                if (out_valid !== 1'b1 || sb.size() == 0 || got_rec !== sb[0]) begin
                    errors++;
                    $display("[TB] FAIL held_output: valid=%b got %h, need valid=1 and first record",
                             out_valid, got_rec);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
                idx++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (idx !== 2) begin
            errors++;
            $display("[TB] FAIL accepts_when_full: got %0d, need 2", idx);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && pops < 4; c++) begin
            if (idx < 4) set_in(1'b1, ba[idx], bb[idx], 1'b0);
            else         in_valid = 1'b0;
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                got_rec = {out_sum, out_cout, out_ovf, out_zero};
                pops++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL bp_spurious: got %h with empty scoreboard", got_rec);
                end else begin
                    exp_rec = sb.pop_front();
                    if (got_rec !== exp_rec) begin
                        errors++;
                        $display("[TB] FAIL bp_order: got %h, need %h", got_rec, exp_rec);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
                idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (pops !== 4 || sb.size() !== 0) begin
            errors++;
            $display("[TB] FAIL bp_drain: got %0d pops, %0d left, need 4 pops, 0 left", pops, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int pops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) set_in(1'b1, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            else        in_valid = 1'b0;
            @(negedge clk);
            if (i < 16) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_in_ready[%0d]: got %b, need 1", i, in_ready);
                end
            end
            if (i >= 1 && i <= 16) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_out_valid[%0d]: got %b, need 1", i, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                got_rec = {out_sum, out_cout, out_ovf, out_zero};
                pops++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_spurious: got %h with empty scoreboard", got_rec);
                end else begin
                    exp_rec = sb.pop_front();
                    if (got_rec !== exp_rec) begin
                        errors++;
                        $display("[TB] FAIL b2b_result[%0d]: got %h, need %h", i, got_rec, exp_rec);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
            @(posedge clk);
            #1;
        end
        checks++;
        if (pops !== 16) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d results, need 16", pops);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            set_in(1'b1, 8'h40 + 8'(c), 8'h03, 1'b0);
            @(negedge clk);
            if (in_valid && in_ready) sb.push_back(cur_exp);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        set_in(1'b1, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_in_ready: got %b, need 0", in_ready);
        end
        @(posedge clk);
        #1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || out_sum !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_clear: valid=%b sum=%h, need valid=0 sum=00", out_valid, out_sum);
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) set_in(1'b1, 8'h0F, 8'h01, 1'b0);
            else        in_valid = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL post_reset_in_ready: got %b, need 1", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                got_rec = {out_sum, out_cout, out_ovf, out_zero};
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stale_record: got %h after reset", got_rec);
                end else begin
                    exp_rec = sb.pop_front();
                    if (got_rec !== exp_rec) begin
                        errors++;
                        $display("[TB] FAIL post_reset_result: got %h, need %h", got_rec, exp_rec);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("[TB] FAIL post_reset_drain: %0d records left, need 0", sb.size());
        end
    endtask

    // Scenario sequence.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
